// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: word-addressed PC, IF/ID pipeline register and a
// BOOT/RUN/HALT control FSM with branch/jump redirect, stall, flush and halt.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  input  logic [15:0] instruction,
  output logic [31:0] read_address,
  output logic [15:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        halted
);

  // MEM_DEPTH is a power of two, so modulo reduces to a mask.
  localparam logic [31:0] AddrMask = 32'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_inc;

  assign pc_inc       = pc_q + 32'd1;
  assign read_address = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= StBoot;
      pc_q              <= RESET_PC & AddrMask;
      if_id_instruction <= 16'h0000;
      if_id_pc_plus1    <= 32'd0;
      if_id_valid       <= 1'b0;
      fetch_count       <= 32'd0;
      halted            <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          if (halt) begin
            state_q     <= StHalt;
            halted      <= 1'b1;
            if_id_valid <= 1'b0;
          end else if (branch_taken) begin
            pc_q        <= branch_target & AddrMask;
            if_id_valid <= 1'b0;
          end else if (jump) begin
            pc_q        <= jump_target & AddrMask;
            if_id_valid <= 1'b0;
          end else if (stall) begin
            // A held valid is not a new delivery, so fetch_count is untouched.
            if (flush) if_id_valid <= 1'b0;
          end else begin
            pc_q              <= pc_inc & AddrMask;
            if_id_instruction <= instruction;
            if_id_pc_plus1    <= pc_inc;
            if_id_valid       <= ~flush;
            if (!flush) fetch_count <= fetch_count + 32'd1;
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StBoot;
      endcase
    end
  end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'd0: PC value loaded on reset.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 256, power of two: instruction memory depth in 16-bit words.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port stall, input, 1 bit: hold PC and the IF/ID register.
REQ-007 The block SHALL have port flush, input, 1 bit: invalidate the IF/ID register.
REQ-008 The block SHALL have port branch_taken, input, 1 bit: branch redirect request.
REQ-009 The block SHALL have port branch_target, input, 32 bits: branch destination word address.
REQ-010 The block SHALL have port jump, input, 1 bit: jump redirect request.
REQ-011 The block SHALL have port jump_target, input, 32 bits: jump destination word address.
REQ-012 The block SHALL have port halt, input, 1 bit: stop fetching.
REQ-013 The block SHALL have port instruction, input, 16 bits: combinational data from instruction memory at read_address.
REQ-014 The block SHALL have port read_address, output, 32 bits: current PC, driven to instruction memory.
REQ-015 The block SHALL have port if_id_instruction, output, 16 bits: registered fetched instruction.
REQ-016 The block SHALL have port if_id_pc_plus1, output, 32 bits: registered PC+1 of that instruction.
REQ-017 The block SHALL have port if_id_valid, output, 1 bit: IF/ID contents are a real instruction.
REQ-018 The block SHALL have port fetch_count, output, 32 bits: number of instructions delivered to IF/ID with valid=1.
REQ-019 The block SHALL have port halted, output, 1 bit: FSM is in HALT.

Function
REQ-020 The FSM SHALL have exactly three states: BOOT, RUN and HALT.
REQ-021 Reset SHALL place the FSM in BOOT; BOOT SHALL unconditionally go to RUN on the next edge, with PC held and no IF/ID capture.
REQ-022 In RUN, halt=1 SHALL go to HALT on the next edge; HALT SHALL be left only by reset.
REQ-023 In HALT, PC, IF/ID and fetch_count SHALL hold, if_id_valid SHALL be cleared on HALT entry, and halted SHALL be 1.
REQ-024 read_address SHALL equal the PC register, addressed in words (increment 1, not 4).
REQ-025 In RUN, each edge SHALL apply exactly one action, by priority: halt > redirect > stall > sequential.
REQ-026 Redirect: branch_taken=1 SHALL load PC with branch_target mod MEM_DEPTH; otherwise jump=1 SHALL load PC with jump_target mod MEM_DEPTH; in both cases if_id_valid SHALL become 0, and stall SHALL be ignored.
REQ-027 If branch_taken and jump are both 1, branch_taken SHALL win.
REQ-028 Sequential: PC SHALL become (PC+1) mod MEM_DEPTH, so MEM_DEPTH-1 wraps to 0.
REQ-029 Sequential: IF/ID SHALL capture instruction and PC+1 (unwrapped, 32-bit), and if_id_valid SHALL become NOT flush.
REQ-030 Stall without redirect SHALL hold PC and if_id_instruction/if_id_pc_plus1.
REQ-031 Stall with flush SHALL clear if_id_valid.
REQ-032 Stall without flush SHALL hold if_id_valid.
REQ-033 fetch_count SHALL increment (mod 2^32) on each edge where if_id_valid is written to 1 from a new capture; a held (stalled) valid SHALL NOT count.
REQ-034 Fetch latency SHALL be 1 cycle: the instruction at PC=N appears on if_id_instruction after the edge that advances PC from N.

Reset
REQ-035 Asserting reset SHALL immediately, without a clock, set PC=RESET_PC mod MEM_DEPTH, if_id_instruction=16'h0000, if_id_pc_plus1=0, if_id_valid=0, fetch_count=0, halted=0, state=BOOT.
REQ-036 Reset asserted mid-stall, mid-redirect or in HALT SHALL produce the REQ-035 values, and fetch SHALL restart from RESET_PC after BOOT.

Verification
REQ-037 Bench: reset release, memory[0..3]=A,B,C,D, no control -> read_address 0,0(BOOT),1,2,3; if_id_instruction A,B,C with valid=1; fetch_count=3 after 3 RUN edges.
REQ-038 Bench: stall=1 for 2 cycles at PC=5 -> read_address stays 5, IF/ID holds, fetch_count unchanged; resumes at 6 after stall drops.
REQ-039 Bench: branch_taken=1, branch_target=40, jump=1, jump_target=80, stall=1 -> next PC=40, if_id_valid=0; the following edge delivers mem[40].
REQ-040 Bench: PC=255, MEM_DEPTH=256 -> next PC=0, if_id_pc_plus1=256; also jump_target=300 -> PC=44.
REQ-041 Bench: halt=1 at PC=10 -> halted=1 next edge, read_address frozen at 10, if_id_valid=0; reset pulse between edges -> outputs zero immediately, PC=RESET_PC.
